mem_dump_serializer: RTL

- Downstream readback stage for the memory bank.
- On command, reads a range of 32-bit words from the bank's synchronous block RAM port and splits each word into 4 bytes.
- Hands the bytes one at a time to the UART transmitter using a start/end handshake.
- Used to dump bank contents over the serial link after programming, for verification.

---
 rtl/mem_dump_serializer.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/mem_dump_serializer.sv
// Reads a range of 32-bit words from a synchronous RAM and streams them byte-wise to a UART
// through a tx_start/tx_end handshake. Define MEM_DUMP_CHECKSUM_EN to append an XOR checksum byte.
module mem_dump_serializer #(
    parameter int unsigned ADDR_WIDTH = 12,
    parameter bit          MSB_FIRST  = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH-1:0] word_count,
    output logic                  mem_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [31:0]           mem_do,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    input  logic                  tx_end,
    output logic                  busy,
    output logic                  done
);

    typedef enum logic [3:0] {
        StIdle,
        StRdReq,
        StRdWait,
        StLatch,
        StSend,
        StWaitTx,
        StNext,
`ifdef MEM_DUMP_CHECKSUM_EN
        StCksum,
        StCkWait,
`endif
        StFin
    } state_e;

    // State entered once every word has been sent (or when the range is empty).
`ifdef MEM_DUMP_CHECKSUM_EN
    localparam state_e StTail = StCksum;
`else
    localparam state_e StTail = StFin;
`endif

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [ADDR_WIDTH-1:0] remaining_q, remaining_d;
    logic [31:0]           word_q, word_d;
    logic [1:0]            byte_idx_q, byte_idx_d;
    logic [7:0]            tx_data_q, tx_data_d;
`ifdef MEM_DUMP_CHECKSUM_EN
    logic [7:0]            cksum_q, cksum_d;
`endif

    function automatic logic [7:0] pick_byte(input logic [31:0] w, input logic [1:0] idx);
        logic [1:0] sel;
        logic [7:0] b;
        sel = MSB_FIRST ? (2'd3 - idx) : idx;
        unique case (sel)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        return b;
    endfunction

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        word_d      = word_q;
        byte_idx_d  = byte_idx_q;
        tx_data_d   = tx_data_q;
`ifdef MEM_DUMP_CHECKSUM_EN
        cksum_d     = cksum_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    addr_d      = base_addr;
                    remaining_d = word_count;
`ifdef MEM_DUMP_CHECKSUM_EN
                    cksum_d     = 8'h00;
`endif
                    state_d     = (word_count == '0) ? StTail : StRdReq;
                end
            end
            StRdReq:  state_d = StRdWait;
            StRdWait: state_d = StLatch;
            StLatch: begin
                word_d     = mem_do;
                byte_idx_d = 2'd0;
                state_d    = StSend;
            end
            StSend:   state_d = StWaitTx;
            StWaitTx: begin
                if (tx_end) begin
                    if (byte_idx_q == 2'd3) begin
                        state_d = StNext;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = StSend;
                    end
                end
            end
            StNext: begin
                addr_d      = addr_q + ADDR_WIDTH'(1);
                remaining_d = remaining_q - ADDR_WIDTH'(1);
                state_d     = (remaining_q == ADDR_WIDTH'(1)) ? StTail : StRdReq;
            end
`ifdef MEM_DUMP_CHECKSUM_EN
            StCksum:  state_d = StCkWait;
            StCkWait: if (tx_end) state_d = StFin;
`endif
            StFin:    state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        // tx_data is loaded on the edge that enters a send state, so it is valid with tx_start.
        if (state_d == StSend) begin
            tx_data_d = pick_byte(word_d, byte_idx_d);
`ifdef MEM_DUMP_CHECKSUM_EN
            cksum_d   = cksum_d ^ tx_data_d;
`endif
        end
`ifdef MEM_DUMP_CHECKSUM_EN
        if (state_d == StCksum) tx_data_d = cksum_d;
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            remaining_q <= '0;
            word_q      <= '0;
            byte_idx_q  <= '0;
            tx_data_q   <= '0;
`ifdef MEM_DUMP_CHECKSUM_EN
            cksum_q     <= '0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            word_q      <= word_d;
            byte_idx_q  <= byte_idx_d;
            tx_data_q   <= tx_data_d;
`ifdef MEM_DUMP_CHECKSUM_EN
            cksum_q     <= cksum_d;
`endif
        end
    end

    assign mem_en   = (state_q == StRdReq);
    assign mem_addr = addr_q;
    assign tx_data  = tx_data_q;
    assign busy     = (state_q != StIdle);
    assign done     = (state_q == StFin);
`ifdef MEM_DUMP_CHECKSUM_EN
    assign tx_start = (state_q == StSend) || (state_q == StCksum);
`else
    assign tx_start = (state_q == StSend);
`endif

endmodule
